// File: rtl/tri_raster_scan.sv
// Scan-point generator: clips a triangle's bounding box to the screen and walks it in raster order,
// forwarding points that the downstream tester reports as covered on a valid/ready pixel stream.
module tri_raster_scan #(
  parameter int COORD_W = 12,
  parameter int SCR_W   = 640,
  parameter int SCR_H   = 480
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tri_valid,
  output logic                        tri_ready,
  input  logic signed [COORD_W-1:0]   p1x,
  input  logic signed [COORD_W-1:0]   p1y,
  input  logic signed [COORD_W-1:0]   p2x,
  input  logic signed [COORD_W-1:0]   p2y,
  input  logic signed [COORD_W-1:0]   p3x,
  input  logic signed [COORD_W-1:0]   p3y,
  output logic signed [COORD_W-1:0]   PTX,
  output logic signed [COORD_W-1:0]   PTY,
  input  logic                        in_tri,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic signed [COORD_W-1:0]   pix_x,
  output logic signed [COORD_W-1:0]   pix_y,
  output logic                        busy,
  output logic                        done,
  output logic [2*COORD_W-1:0]        pix_count
);

  localparam int unsigned CNT_W = 2 * COORD_W;
  localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(SCR_W - 1);
  localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(SCR_H - 1);

  typedef enum logic [1:0] {IDLE, BBOX, SCAN, DONE} state_t;

  state_t state_q, state_d;

  logic signed [COORD_W-1:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic signed [COORD_W-1:0] v1x_d, v1y_d, v2x_d, v2y_d, v3x_d, v3y_d;
  logic signed [COORD_W-1:0] xmin_q, xmax_q, ymax_q;
  logic signed [COORD_W-1:0] xmin_d, xmax_d, ymax_d;
  logic signed [COORD_W-1:0] ptx_d, pty_d, pix_x_d, pix_y_d;
  logic                      pix_valid_d, done_d, tri_ready_d, busy_d;
  logic [CNT_W-1:0]          pix_count_d;

  logic signed [COORD_W-1:0] mnx, mxx, mny, mxy, lo_x, hi_x, lo_y, hi_y;
  logic                      slot_free;

  function automatic logic signed [COORD_W-1:0] smin3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [COORD_W-1:0] smax3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c
  );
    logic signed [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Box intersected with the screen; a box wholly off-screen comes out with lo > hi.
  always_comb begin
    mnx  = smin3(v1x_q, v2x_q, v3x_q);
    mxx  = smax3(v1x_q, v2x_q, v3x_q);
    mny  = smin3(v1y_q, v2y_q, v3y_q);
    mxy  = smax3(v1y_q, v2y_q, v3y_q);
    lo_x = mnx[COORD_W-1] ? '0 : mnx;
    lo_y = mny[COORD_W-1] ? '0 : mny;
    hi_x = (mxx > X_HI) ? X_HI : mxx;
    hi_y = (mxy > Y_HI) ? Y_HI : mxy;
  end

  assign slot_free = !pix_valid || pix_ready;

  always_comb begin
    state_d     = state_q;
    v1x_d       = v1x_q;
    v1y_d       = v1y_q;
    v2x_d       = v2x_q;
    v2y_d       = v2y_q;
    v3x_d       = v3x_q;
    v3y_d       = v3y_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymax_d      = ymax_q;
    ptx_d       = PTX;
    pty_d       = PTY;
    pix_x_d     = pix_x;
    pix_y_d     = pix_y;
    pix_valid_d = pix_valid;
    pix_count_d = pix_count;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          v1x_d       = p1x;
          v1y_d       = p1y;
          v2x_d       = p2x;
          v2y_d       = p2y;
          v3x_d       = p3x;
          v3y_d       = p3y;
          pix_count_d = '0;
          state_d     = BBOX;
        end
      end
      BBOX: begin
        xmin_d = lo_x;
        xmax_d = hi_x;
        ymax_d = hi_y;
        if ((lo_x > hi_x) || (lo_y > hi_y)) begin
          state_d = DONE;
        end else begin
          ptx_d   = lo_x;
          pty_d   = lo_y;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // A stalled output slot freezes the walk so every point is sampled exactly once.
        if (slot_free) begin
          if (in_tri) begin
            pix_x_d     = PTX;
            pix_y_d     = PTY;
            pix_valid_d = 1'b1;
            if (pix_count != '1) pix_count_d = pix_count + 1'b1;
          end else begin
            pix_valid_d = 1'b0;
          end
          if (PTX < xmax_q) begin
            ptx_d = PTX + 1'b1;
          end else if (PTY < ymax_q) begin
            ptx_d = xmin_q;
            pty_d = PTY + 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (pix_valid) begin
          if (pix_ready) pix_valid_d = 1'b0;
        end else if (!done) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tri_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      v1x_q     <= '0;
      v1y_q     <= '0;
      v2x_q     <= '0;
      v2y_q     <= '0;
      v3x_q     <= '0;
      v3y_q     <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymax_q    <= '0;
      PTX       <= '0;
      PTY       <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
      pix_count <= '0;
      done      <= 1'b0;
      tri_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      v1x_q     <= v1x_d;
      v1y_q     <= v1y_d;
      v2x_q     <= v2x_d;
      v2y_q     <= v2y_d;
      v3x_q     <= v3x_d;
      v3y_q     <= v3y_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymax_q    <= ymax_d;
      PTX       <= ptx_d;
      PTY       <= pty_d;
      pix_x     <= pix_x_d;
      pix_y     <= pix_y_d;
      pix_valid <= pix_valid_d;
      pix_count <= pix_count_d;
      done      <= done_d;
      tri_ready <= tri_ready_d;
      busy      <= busy_d;
    end
  end

endmodule
